hdmi_pkt_sched: RTL and testbench

HDMI_PKT_SCHED -- requirements
Module: hdmi_pkt_sched

---
 rtl/hdmi_pkg.sv | 42 ++++
 rtl/pkt_arbiter.sv | 78 +++++++
 rtl/hdmi_pkt_sched.sv | 179 +++++++++++++++++
 tb/tb_hdmi_pkt_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared encodings for the HDMI packet scheduler: period types,
//               control codes, phase lengths and scheduler states.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

  // Period type driven towards the TMDS encoder
  typedef enum logic [1:0] {
    GUARD       = 2'b00,
    CTL_PERIOD  = 2'b01,
    DATA_ISLAND = 2'b10,
    VIDEO_DATA  = 2'b11
  } period_t;

  // Control-period codes: plain blanking and data-island preamble
  localparam logic [3:0] CTL_IDLE     = 4'h1;
  localparam logic [3:0] CTL_PREAMBLE = 4'h5;

  // Phase lengths in pixel clocks
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PKT_LEN      = 32;

  // Island start offset after the active width, and the fit margins:
  // packet k fits when width + FIT_HEAD + 32k <= raw - FIT_TAIL
  localparam int START_OFS = 3;
  localparam int FIT_HEAD  = 47;
  localparam int FIT_TAIL  = 14;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_LGUARD   = 3'd2,
    S_DATA     = 3'd3,
    S_TGUARD   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pkt_arbiter
// Description : Combinational request-to-one-hot arbiter. Build macro
//               PKT_SCHED_ROUNDROBIN_EN selects round-robin with a registered
//               pointer; otherwise fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_arbiter #(
  parameter int NREQ = 2
) (
`ifdef PKT_SCHED_ROUNDROBIN_EN
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
`endif
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

`ifdef PKT_SCHED_ROUNDROBIN_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic          found;
  int            best;
  int            win;
  int            dist;

  // Pick the requester closest to the pointer, searching upward with wrap
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    best    = NREQ;
    win     = 0;
    dist    = 0;
    for (int i = 0; i < NREQ; i++) begin
      dist = i - int'(ptr);
      if (dist < 0) dist = dist + NREQ;
      if (req[i] && (dist < best)) begin
        best = dist;
        win  = i;
      end
    end
    found = (best < NREQ);
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = found && (i == win);
    end
    win_idx = PW'(win);
  end

  // Pointer moves to one past the winner whenever a grant is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end
`else
  logic found;

  // Lowest-index requester wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/hdmi_pkt_sched.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkt_sched
// Description : Schedules one data island per line in horizontal blanking:
//               preamble, leading guard, up to MAXPKT 32-cycle packets and a
//               trailing guard. All outputs are registered. Build macro
//               PKT_SCHED_ROUNDROBIN_EN selects round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_pkt_sched
  import hdmi_pkg::*;
#(
  parameter int HW     = 12,
  parameter int NREQ   = 2,
  parameter int MAXPKT = 2
) (
  input  logic            i_pixclk,
  input  logic            i_reset_n,
  input  logic [HW-1:0]   i_hpos,
  input  logic [HW-1:0]   i_hm_width,
  input  logic [HW-1:0]   i_hm_raw,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [4:0]      o_pkt_idx,
  output logic [1:0]      o_type,
  output logic [3:0]      o_ctl,
  output logic            o_active
);

  localparam int KW = $clog2(MAXPKT + 1);

  state_t          state, state_nx;
  logic [4:0]      cnt, cnt_nx;
  logic [KW-1:0]   pkt, pkt_nx;
  logic [NREQ-1:0] arb_grant, grant_nx;
  logic [1:0]      type_nx;
  logic [3:0]      ctl_nx;
  logic [4:0]      idx_nx;
  logic            at_start;
  logic            first_fits;
  logic            more_ok;

  // Packet k fits when the whole packet plus trailing margin ends before raw;
  // evaluated in 32 bits so neither side can wrap.
  function automatic logic fits(input logic [HW-1:0] w, input logic [HW-1:0] r,
                                input int k);
    logic [31:0] need;
    need = 32'(w) + 32'(FIT_HEAD + FIT_TAIL) + 32'(k) * 32'(PKT_LEN);
    return need <= 32'(r);
  endfunction

  assign at_start   = ({1'b0, i_hpos} == ({1'b0, i_hm_width} + (HW+1)'(START_OFS)));
  assign first_fits = fits(i_hm_width, i_hm_raw, 0);
  assign more_ok    = ((int'(pkt) + 1) < MAXPKT) && fits(i_hm_width, i_hm_raw, int'(pkt) + 1);

`ifdef PKT_SCHED_ROUNDROBIN_EN
  logic arb_take;
  assign arb_take = (|i_req) &&
                    (((state == S_LGUARD) && (cnt == 5'(GUARD_LEN - 1))) ||
                     ((state == S_DATA) && (cnt == 5'(PKT_LEN - 1)) && more_ok));

  pkt_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (i_pixclk),
    .rst_n   (i_reset_n),
    .advance (arb_take),
    .req     (i_req),
    .grant   (arb_grant)
  );
`else
  pkt_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (i_req),
    .grant   (arb_grant)
  );
`endif

  // Next state, phase counter, packet count and grant
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 5'd1;
    pkt_nx   = pkt;
    grant_nx = o_grant;
    case (state)
      S_IDLE: begin
        cnt_nx   = '0;
        pkt_nx   = '0;
        grant_nx = '0;
        if (at_start && (|i_req) && first_fits) state_nx = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (cnt == 5'(PREAMBLE_LEN - 1)) begin
          state_nx = S_LGUARD;
          cnt_nx   = '0;
        end
      end
      S_LGUARD: begin
        if (cnt == 5'(GUARD_LEN - 1)) begin
          cnt_nx = '0;
          if (|i_req) begin
            state_nx = S_DATA;
            grant_nx = arb_grant;
            pkt_nx   = '0;
          end else begin
            state_nx = S_TGUARD;
          end
        end
      end
      S_DATA: begin
        if (cnt == 5'(PKT_LEN - 1)) begin
          cnt_nx = '0;
          if ((|i_req) && more_ok) begin
            grant_nx = arb_grant;
            pkt_nx   = pkt + KW'(1);
          end else begin
            state_nx = S_TGUARD;
            grant_nx = '0;
          end
        end
      end
      S_TGUARD: begin
        if (cnt == 5'(GUARD_LEN - 1)) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          grant_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        pkt_nx   = '0;
        grant_nx = '0;
      end
    endcase
  end

  // Output values for the upcoming cycle, decoded from the next state
  always_comb begin
    type_nx = CTL_PERIOD;
    ctl_nx  = CTL_IDLE;
    idx_nx  = '0;
    case (state_nx)
      S_PREAMBLE: ctl_nx = CTL_PREAMBLE;
      S_LGUARD:   type_nx = GUARD;
      S_TGUARD:   type_nx = GUARD;
      S_DATA: begin
        type_nx = DATA_ISLAND;
        idx_nx  = cnt_nx;
      end
      default: begin
        type_nx = CTL_PERIOD;
        ctl_nx  = CTL_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any island with no guard
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pkt       <= '0;
      o_grant   <= '0;
      o_pkt_idx <= '0;
      o_type    <= CTL_PERIOD;
      o_ctl     <= CTL_IDLE;
      o_active  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pkt       <= pkt_nx;
      o_grant   <= grant_nx;
      o_pkt_idx <= idx_nx;
      o_type    <= type_nx;
      o_ctl     <= ctl_nx;
      o_active  <= (state_nx != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pkt_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_pkt_sched
// Description : Self-checking bench for hdmi_pkt_sched. A per-island offset
//               model predicts every output cycle by cycle across directed and
//               randomized lines. Honours PKT_SCHED_ROUNDROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_pkt_sched;

  localparam int HW     = 12;
  localparam int NREQ   = 2;
  localparam int MAXPKT = 2;

  logic            clk;
  logic            rst_n;
  logic [HW-1:0]   hpos;
  logic [HW-1:0]   width;
  logic [HW-1:0]   raw;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [4:0]      pkt_idx;
  logic [1:0]      typ;
  logic [3:0]      ctl;
  logic            active;

  int checks = 0;
  int errors = 0;

  hdmi_pkt_sched #(.HW(HW), .NREQ(NREQ), .MAXPKT(MAXPKT)) dut (
    .i_pixclk   (clk),
    .i_reset_n  (rst_n),
    .i_hpos     (hpos),
    .i_hm_width (width),
    .i_hm_raw   (raw),
    .i_req      (req),
    .o_grant    (grant),
    .o_pkt_idx  (pkt_idx),
    .o_type     (typ),
    .o_ctl      (ctl),
    .o_active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t hpos=%0d: got %0h expected %0h", tag, $time, hpos, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Island described by its offset from the start cycle S (S itself is 0).
  bit              m_busy;
  int              m_off;
  int              m_k;
  int              m_tg;     // offset of first trailing-guard cycle, -1 if not yet known
  logic [NREQ-1:0] m_grant;
  int              m_ptr;

  function automatic bit m_fits(int w, int r, int k);
    return (w + 47 + 32 * k) <= (r - 14);
  endfunction

  task automatic m_arbitrate(input logic [NREQ-1:0] r);
    m_grant = '0;
`ifdef PKT_SCHED_ROUNDROBIN_EN
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (m_ptr + i) % NREQ;
      if (r[j]) begin
        m_grant[j] = 1'b1;
        m_ptr = (j + 1) % NREQ;
        break;
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        m_grant[i] = 1'b1;
        break;
      end
    end
`endif
  endtask

  task automatic m_reset();
    m_busy  = 0;
    m_off   = 0;
    m_k     = 0;
    m_tg    = -1;
    m_grant = '0;
    m_ptr   = 0;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge
  task automatic m_step();
    int w, r;
    w = int'(width);
    r = int'(raw);
    if (!m_busy) begin
      if ((int'(hpos) == w + 3) && (req != '0) && m_fits(w, r, 0)) begin
        m_busy  = 1;
        m_off   = 1;
        m_k     = 0;
        m_tg    = -1;
        m_grant = '0;
      end
    end else begin
      if (m_off == 10) begin
        if (req != '0) m_arbitrate(req);
        else m_tg = 11;
      end else if ((m_tg < 0) && (m_off >= 42) && (((m_off - 42) % 32) == 0)) begin
        if ((req != '0) && (m_k + 1 < MAXPKT) && m_fits(w, r, m_k + 1)) begin
          m_k++;
          m_arbitrate(req);
        end else begin
          m_tg = m_off + 1;
        end
      end
      if ((m_tg >= 0) && (m_off == m_tg + 1)) m_busy = 0;
      else m_off++;
    end
  endtask

  task automatic compare_all();
    logic [1:0]      e_type;
    logic [3:0]      e_ctl;
    logic            e_act;
    logic [NREQ-1:0] e_grant;
    logic [4:0]      e_idx;
    e_type  = 2'b01;
    e_ctl   = 4'h1;
    e_act   = 1'b0;
    e_grant = '0;
    e_idx   = '0;
    if (m_busy) begin
      e_act = 1'b1;
      if (m_off <= 8) begin
        e_ctl = 4'h5;
      end else if (m_off <= 10) begin
        e_type = 2'b00;
      end else if ((m_tg >= 0) && (m_off >= m_tg)) begin
        e_type = 2'b00;
      end else begin
        e_type  = 2'b10;
        e_idx   = 5'((m_off - 11) % 32);
        e_grant = m_grant;
      end
    end
    check("type",   32'(typ),     32'(e_type));
    check("active", 32'(active),  32'(e_act));
    check("grant",  32'(grant),   32'(e_grant));
    check("idx",    32'(pkt_idx), 32'(e_idx));
    if (e_type == 2'b01) check("ctl", 32'(ctl), 32'(e_ctl));
  endtask

  // Request pattern per line mode
  function automatic logic [NREQ-1:0] pick_req(int mode, int h, int w);
    case (mode)
      0:       return 2'b01;
      1:       return 2'b11;
      2:       return (h < w + 45) ? 2'b10 : 2'b00;
      3:       return NREQ'($urandom_range(0, 3));
      default: return 2'b00;
    endcase
  endfunction

  // One full line; optional asynchronous reset at S+20
  task automatic run_line(input int w, input int r, input int mode, input bit do_rst);
    for (int h = 0; h < r; h++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      hpos  = HW'(h);
      width = HW'(w);
      raw   = HW'(r);
      req   = pick_req(mode, h, w);
      if (do_rst && (h == w + 23)) begin
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        compare_all();
      end
      @(posedge clk);
      if (rst_n) m_step();
      #1 compare_all();
      if (errors >= 50) break;
    end
  endtask

  initial begin
    int w, r;
    rst_n = 1'b0;
    hpos  = '0;
    width = HW'(640);
    raw   = HW'(800);
    req   = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    @(negedge clk) rst_n = 1'b1;

    // Two packets of requester 0, then again on the next line
    run_line(640, 800, 0, 1'b0);
    if (errors < 50) run_line(640, 800, 0, 1'b0);
    // Packet 0 does not fit: no island
    if (errors < 50) run_line(640, 700, 1, 1'b0);
    // Both requesting: arbitration order across two lines
    if (errors < 50) run_line(640, 800, 1, 1'b0);
    if (errors < 50) run_line(640, 800, 1, 1'b0);
    // Request drops in the last DATA cycle of packet 0
    if (errors < 50) run_line(640, 800, 2, 1'b0);
    // Reset mid-island, next island on the following line
    if (errors < 50) run_line(640, 800, 0, 1'b1);
    if (errors < 50) run_line(640, 800, 0, 1'b0);
    // Room for only one packet
    if (errors < 50) run_line(640, 725, 1, 1'b0);
    // Randomized geometry and requests
    for (int n = 0; n < 12; n++) begin
      if (errors >= 50) break;
      w = int'($urandom_range(100, 300));
      r = w + int'($urandom_range(40, 200));
      run_line(w, r, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
